demux_rr_scheduler: RTL and testbench



---
 rtl/demux_sched_pkg.sv | 12 +
 rtl/demux_rr_arbiter.sv | 21 ++
 rtl/demux_rr_scheduler.sv | 81 ++++++++
 tb/tb_demux_rr_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared state type, default sizes and one-hot decode helper
package demux_sched_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_BURST_LEN = 4;
  function automatic int onehot2bin(input logic [31:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) b = b | i;
    return b;
  endfunction
endpackage

// File: rtl/demux_rr_arbiter.sv
// demux_rr_arbiter: combinational round-robin pick starting after ptr
module demux_rr_arbiter import demux_sched_pkg::*; #(
  parameter int N = DEF_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx
);
  // scan ptr+1 .. ptr+N (mod N) and keep the first requester found
  always_comb begin
    int c;
    gnt = '0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (gnt == '0 && req[SEL_W'(c)]) gnt[SEL_W'(c)] = 1'b1;
    end
    idx = SEL_W'(onehot2bin(32'(gnt)));
  end
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin burst scheduler driving a 1xN demux (sel/en/d); DEMUX_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority
module demux_rr_scheduler import demux_sched_pkg::*; #(
  parameter int N = DEF_N,
  parameter int BURST_LEN = DEF_BURST_LEN,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             din_valid,
  input  logic             din,
  output logic             din_ready,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             d,
  output logic             busy,
  output logic             burst_done
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx;
  logic [SEL_W-1:0] rr_ptr, win_idx, sel_nx;
  logic [N-1:0] win_oh, grant_nx;
  logic accept, last, en_nx, d_nx, done_nx, busy_nx;

  demux_rr_arbiter #(.N(N)) u_arb (.req(req), .ptr(rr_ptr), .gnt(win_oh), .idx(win_idx));

  assign din_ready = state == SEND && req[sel];
  assign accept = din_valid && din_ready;
  assign last = bit_cnt == CNT_W'(BURST_LEN - 1);

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // claim on any request; leave SEND on owner dropping req or on the final accepted bit
  always_comb
    state_nx = state == IDLE ? (|req ? SEND : IDLE) : (!din_ready || (accept && last)) ? IDLE : SEND;

  // next values of the registered demux and status outputs
  always_comb begin
    sel_nx = state == IDLE && |req ? win_idx : sel;
    grant_nx = state_nx == IDLE ? '0 : state == IDLE ? win_oh : grant;
    busy_nx = state_nx == SEND;
    en_nx = accept;
    d_nx = accept ? din : d;
    done_nx = accept && last;
    cnt_nx = state == SEND && state_nx == SEND ? bit_cnt + CNT_W'(accept) : '0;
  end

  // registered outputs and bit counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel <= '0;
      grant <= '0;
      busy <= 1'b0;
      en <= 1'b0;
      d <= 1'b0;
      burst_done <= 1'b0;
      bit_cnt <= '0;
    end else begin
      sel <= sel_nx;
      grant <= grant_nx;
      busy <= busy_nx;
      en <= en_nx;
      d <= d_nx;
      burst_done <= done_nx;
      bit_cnt <= cnt_nx;
    end

`ifdef DEMUX_SCHED_FIXED_PRIO_EN
  assign rr_ptr = SEL_W'(N - 1);
`else
  // the channel just served becomes lowest priority for the next pick
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= SEL_W'(N - 1);
    else if (state == SEND && state_nx == IDLE) rr_ptr <= sel;
`endif
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_demux_rr_scheduler;
  localparam int N = 4;
`ifdef DEMUX_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, din_valid, din, din_ready, en, d, busy, burst_done;
  logic [N-1:0] req, grant;
  logic [1:0] sel;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit rb;
    logic [3:0] req;
    logic v, di, rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic en, d, busy, done;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  demux_rr_scheduler #(.N(N), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .grant(grant), .sel(sel), .en(en), .d(d),
    .busy(busy), .burst_done(burst_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    din_valid = 1'b0;
    din = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ch;
    rst = 1'b1;
    req = '0;
    din_valid = 1'b0;
    din = 1'b0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_ready", 32'(din_ready), 0);
    rst = 1'b0;
    step();

    // single burst on channel 0, data 1,0,1,1
    tv.push_back('{1, 4'b0001, 1, 1, 0, 4'b0001, 0, 0, 0, 1, 0});
    tv.push_back('{0, 4'b0001, 1, 1, 1, 4'b0001, 0, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0001, 1, 0, 1, 4'b0001, 0, 1, 0, 1, 0});
    tv.push_back('{0, 4'b0001, 1, 1, 1, 4'b0001, 0, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0001, 1, 1, 1, 4'b0000, 0, 1, 1, 0, 1});
    tv.push_back('{0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0});
    // channel 2 with toggling valid: en trails accepts, d holds on gaps
    tv.push_back('{1, 4'b0100, 0, 0, 0, 4'b0100, 2, 0, 0, 1, 0});
    tv.push_back('{0, 4'b0100, 1, 1, 1, 4'b0100, 2, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0100, 0, 0, 1, 4'b0100, 2, 0, 1, 1, 0});
    tv.push_back('{0, 4'b0100, 1, 0, 1, 4'b0100, 2, 1, 0, 1, 0});
    tv.push_back('{0, 4'b0100, 0, 1, 1, 4'b0100, 2, 0, 0, 1, 0});
    tv.push_back('{0, 4'b0100, 1, 1, 1, 4'b0100, 2, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0100, 0, 0, 1, 4'b0100, 2, 0, 1, 1, 0});
    tv.push_back('{0, 4'b0100, 1, 1, 1, 4'b0000, 2, 1, 1, 0, 1});
    tv.push_back('{0, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 1, 0, 0});
    // abort on channel 1 after two bits, then 0011 goes to channel 0
    tv.push_back('{1, 4'b0010, 0, 0, 0, 4'b0010, 1, 0, 0, 1, 0});
    tv.push_back('{0, 4'b0010, 1, 1, 1, 4'b0010, 1, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0010, 1, 1, 1, 4'b0010, 1, 1, 1, 1, 0});
    tv.push_back('{0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 1, 0, 0});
    tv.push_back('{0, 4'b0011, 0, 0, 0, 4'b0001, 0, 0, 1, 1, 0});
    tv.push_back('{0, 4'b0011, 0, 0, 1, 4'b0001, 0, 0, 1, 1, 0});

    foreach (tv[i]) begin
      if (tv[i].rb) do_reset();
      req = tv[i].req;
      din_valid = tv[i].v;
      din = tv[i].di;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(din_ready), 32'(tv[i].rdy));
      step();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].gnt));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tv[i].sel));
      chk($sformatf("v%0d_en", i), 32'(en), 32'(tv[i].en));
      chk($sformatf("v%0d_d", i), 32'(d), 32'(tv[i].d));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_done", i), 32'(burst_done), 32'(tv[i].done));
    end

    // all channels requesting: rotation 0,1,2,3,0 (always 0 in fixed priority)
    do_reset();
    req = 4'b1111;
    din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ch = FIXED ? 0 : k % N;
      #1;
      chk($sformatf("rr%0d_idle_ready", k), 32'(din_ready), 0);
      step();
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << ch));
      chk($sformatf("rr%0d_sel", k), 32'(sel), 32'(ch));
      chk($sformatf("rr%0d_en_low", k), 32'(en), 0);
      chk($sformatf("rr%0d_done_low", k), 32'(burst_done), 0);
      for (int b = 0; b < 4; b++) begin
        din = ((k + b) % 2) != 0;
        #1;
        step();
        chk($sformatf("rr%0d_b%0d_en", k, b), 32'(en), 1);
        chk($sformatf("rr%0d_b%0d_d", k, b), 32'(d), 32'(((k + b) % 2) != 0));
        chk($sformatf("rr%0d_b%0d_done", k, b), 32'(burst_done), 32'(b == 3));
      end
      chk($sformatf("rr%0d_end_grant", k), 32'(grant), 0);
      chk($sformatf("rr%0d_end_busy", k), 32'(busy), 0);
    end

    // reset during bit 2 of a channel 2 burst clears outputs without a clock
    do_reset();
    req = 4'b0100;
    din_valid = 1'b1;
    din = 1'b1;
    step();
    step();
    step();
    chk("mid_sel_pre", 32'(sel), 2);
    chk("mid_en_pre", 32'(en), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_en", 32'(en), 0);
    chk("mid_grant", 32'(grant), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_sel", 32'(sel), 0);
    chk("mid_d", 32'(d), 0);
    chk("mid_ready", 32'(din_ready), 0);
    rst = 1'b0;
    req = 4'b1111;
    din_valid = 1'b0;
    step();
    chk("post_rst_grant", 32'(grant), 1);
    chk("post_rst_sel", 32'(sel), 0);
    chk("post_rst_busy", 32'(busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
